apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB completer (responder) at the far end of the AHB-to-APB bridge's APB port.
- Claims one bit of the bridge's 3-bit Pselx select bus.
- Contains a bank of 32-bit registers, a 3-state APB transfer FSM, address/alignment error response and protocol-violation detection.
- Used as the peripheral in bridge integration tests and as a standalone verification target.

Parameters:
- SLV_INDEX, 0, Pselx bit this instance responds to (0..2)
- NUM_REGS, 16, number of 32-bit registers (power of 2, 2..256)
- ID_VALUE, 32'hA2B0_0593, read-only contents of register 0
- WAIT_CYCLES, 2, wait states per transfer when APB_SLV_WAIT_EN is defined (0..15)

Ports:
- Hclk  in  1  clock shared with the bridge
- Hreset  in  1  synchronous, active-high reset
- Pselx  in  3  peripheral selects from bridge; sel = Pselx[SLV_INDEX]
- Penable  in  1  APB enable (ACCESS phase)
- Pwrite  in  1  1 = write, 0 = read
- Paddr  in  32  byte address
- Pwdata  in  32  write data
- Prdata  out  32  read data
- Pready  out  1  transfer completion
- Pslverr  out  1  error response, valid when Pready=1 in ACCESS
- prot_err  out  1  sticky protocol-violation flag
- xfer_count  out  16  completed transfers (OK or error), wraps at 16'hFFFF -> 0

Behaviour:
- Reset (Hreset=1 at a rising Hclk edge):
  - FSM -> IDLE; all registers 1..NUM_REGS-1 cleared to 0.
  - Prdata=0, Pslverr=0, prot_err=0, xfer_count=0.
  - Pready=1 without APB_SLV_WAIT_EN, 0 with it.
- Reset mid-transfer aborts the transfer; a pending write never commits.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - sel=1, Penable=0 -> SETUP; capture Paddr, Pwrite, Pwdata.
  - sel=1, Penable=1 -> stay IDLE; set prot_err.
- SETUP:
  - Always -> ACCESS.
  - If the next cycle lacks sel=1 and Penable=1, or Paddr/Pwrite differ from the captured values, set prot_err and go IDLE; no write, xfer_count unchanged.
  - On SETUP->ACCESS, load Prdata with the read data (0 for writes or errors), so Prdata is stable for the whole ACCESS phase.
- ACCESS:
  - Completion cycle is the cycle with Pready=1.
  - On completion: write commits if no error; xfer_count increments.
  - Next state: SETUP if sel=1 and Penable=0 (back-to-back, capture new request), else IDLE.
  - Prdata returns to 0 in the cycle after completion.
  - Inputs must stay stable while Pready=0; a change sets prot_err and the transfer still completes with captured values.
- Decode:
  - offset = Paddr[11:0]; index = offset >> 2.
  - Error if Paddr[1:0] != 0 or index >= NUM_REGS.
  - Errors: Pslverr=1 during the completion cycle only, write dropped, Prdata=0.
  - Paddr[31:12] ignored; the bridge performs region decode.
- Register 0 reads ID_VALUE. A write to it is silently dropped (no error).
- Writes take effect at the completion edge. A read of the same register in the immediately following transfer returns the new value.
- prot_err clears only on reset.

Optional Feature:
- APB_SLV_WAIT_EN defined:
  - A 4-bit counter loads WAIT_CYCLES on entering ACCESS.
  - Pready=0 while the counter is nonzero; the counter decrements each cycle.
  - Pready=1 when the counter reaches 0. With WAIT_CYCLES=0 this behaves as zero-wait.
  - Pready is 0 outside ACCESS.
- Not defined:
  - Pready tied to 1 and no counter is instantiated.
  - Every ACCESS lasts exactly one cycle, which matches the bridge's fixed two-cycle APB timing.

Test Plan:
- Write then read: write 32'hDEAD_BEEF to Paddr 32'h8000_0010, then read the same address -> Prdata=32'hDEAD_BEEF in the read ACCESS cycle, Pslverr=0, xfer_count=2.
- ID/read-only: write 32'h1234_5678 to offset 0x000, then read it -> Prdata=32'hA2B0_0593, Pslverr=0.
- Error decode:
  - Read at offset 0x042 (misaligned) -> Pslverr=1, Prdata=0.
  - Write at offset 0x040 with NUM_REGS=16 -> Pslverr=1, no register changes.
- Back-to-back: writes to 0x004, 0x008 and 0x00C with SETUP directly following each ACCESS -> all three commit, FSM never visits IDLE, xfer_count=3.
- Protocol violation: Penable=1 with sel=1 from IDLE -> prot_err=1, no transfer counted. Separately, Paddr changing between SETUP and ACCESS -> prot_err=1, write dropped.
- Wait states and reset (APB_SLV_WAIT_EN, WAIT_CYCLES=2):
  - A read shows Pready low for 2 ACCESS cycles, then high for 1.
  - Hreset asserted during a write's wait cycle -> target register stays 0, FSM in IDLE, xfer_count=0.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of 32-bit registers; register 0 is a read-only ID.
// Optional wait states are enabled by defining APB_SLV_WAIT_EN (WAIT_CYCLES per ACCESS).
module apb_slave_regfile #(
    parameter int          SLV_INDEX   = 0,
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] ID_VALUE    = 32'hA2B0_0593,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr,
    output logic        prot_err,
    output logic [15:0] xfer_count
);

    localparam int         IDX_W    = $clog2(NUM_REGS);
    localparam logic [2:0] SEL_MASK = 3'b001 << SLV_INDEX;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [31:0] prdata_q, prdata_d;
    logic        prot_q, prot_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] regs_q [1:NUM_REGS-1];

    logic             sel;
    logic             capture;
    logic             dec_err;
    logic             done;
    logic             commit;
    logic             unstable;
    logic [9:0]       word_idx;
    logic [IDX_W-1:0] ridx;
    logic [31:0]      rd_val;

    assign sel      = |(Pselx & SEL_MASK);
    assign word_idx = addr_q[11:2];
    assign ridx     = addr_q[IDX_W+1:2];
    assign dec_err  = (addr_q[1:0] != 2'b00) || ({22'd0, word_idx} >= 32'(NUM_REGS));

`ifdef APB_SLV_WAIT_EN
    logic [3:0] wcnt_q, wcnt_d;

    assign Pready = (state_q == ACCESS) && (wcnt_q == 4'd0);
`else
    assign Pready = 1'b1;
`endif

    assign done     = (state_q == ACCESS) && Pready;
    assign commit   = done && write_q && !dec_err && (ridx != '0);
    assign Pslverr  = done && dec_err;
    // Any drift of the held request while the completer is stalling is a violation.
    assign unstable = !(sel && Penable) || (Paddr != addr_q) || (Pwrite != write_q)
                      || (write_q && (Pwdata != wdata_q));

    always_comb begin
        rd_val = '0;
        if (ridx == '0) begin
            rd_val = ID_VALUE;
        end else begin
            rd_val = regs_q[ridx];
        end
    end

    always_comb begin
        state_d  = state_q;
        prdata_d = prdata_q;
        prot_d   = prot_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
`ifdef APB_SLV_WAIT_EN
        wcnt_d   = wcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel && !Penable) begin
                    capture = 1'b1;
                    state_d = SETUP;
                end else if (sel && Penable) begin
                    prot_d = 1'b1;
                end
            end
            SETUP: begin
                if (!(sel && Penable) || (Paddr != addr_q) || (Pwrite != write_q)) begin
                    prot_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d  = ACCESS;
                    prdata_d = (write_q || dec_err) ? 32'd0 : rd_val;
`ifdef APB_SLV_WAIT_EN
                    wcnt_d   = 4'(WAIT_CYCLES);
`endif
                end
            end
            ACCESS: begin
                if (Pready) begin
                    cnt_d    = cnt_q + 16'd1;
                    prdata_d = '0;
                    if (sel && !Penable) begin
                        capture = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (unstable) begin
                        prot_d = 1'b1;
                    end
`ifdef APB_SLV_WAIT_EN
                    wcnt_d = wcnt_q - 4'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign addr_d  = capture ? Paddr  : addr_q;
    assign write_d = capture ? Pwrite : write_q;
    assign wdata_d = capture ? Pwdata : wdata_q;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            prdata_q <= '0;
            prot_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef APB_SLV_WAIT_EN
            wcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            prdata_q <= prdata_d;
            prot_q   <= prot_d;
            cnt_q    <= cnt_d;
`ifdef APB_SLV_WAIT_EN
            wcnt_q   <= wcnt_d;
`endif
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[ridx] <= wdata_q;
        end
    end

    assign Prdata     = prdata_q;
    assign prot_err   = prot_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile; inputs change on the falling edge, outputs are read there too.
module tb_apb_slave_regfile;

    logic        Hclk = 1'b0;
    logic        Hreset = 1'b1;
    logic [2:0]  Pselx = 3'b000;
    logic        Penable = 1'b0;
    logic        Pwrite = 1'b0;
    logic [31:0] Paddr = '0;
    logic [31:0] Pwdata = '0;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;
    logic        prot_err;
    logic [15:0] xfer_count;

    localparam logic [2:0] SEL   = 3'b001;
    localparam logic [2:0] OTHER = 3'b110;
`ifdef APB_SLV_WAIT_EN
    localparam int   EXP_WAIT     = 2;
    localparam logic EXP_IDLE_RDY = 1'b0;
`else
    localparam int   EXP_WAIT     = 0;
    localparam logic EXP_IDLE_RDY = 1'b1;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] rd;
    logic        err;
    int          waits;

    apb_slave_regfile dut (
        .Hclk       (Hclk),
        .Hreset     (Hreset),
        .Pselx      (Pselx),
        .Penable    (Penable),
        .Pwrite     (Pwrite),
        .Paddr      (Paddr),
        .Pwdata     (Pwdata),
        .Prdata     (Prdata),
        .Pready     (Pready),
        .Pslverr    (Pslverr),
        .prot_err   (prot_err),
        .xfer_count (xfer_count)
    );

    always #5 Hclk = ~Hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one bus cycle and return at the following falling edge.
    task automatic cyc(input logic [2:0] s, input logic e, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        Pselx   = s;
        Penable = e;
        Pwrite  = w;
        Paddr   = a;
        Pwdata  = d;
        @(negedge Hclk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(OTHER, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Returns in the completer's completion cycle, before that cycle's inputs are driven.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdat, output logic serr, output int nwait);
        nwait = 0;
        cyc(SEL, 1'b0, w, a, d);
        cyc(SEL, 1'b1, w, a, d);
        while (Pready !== 1'b1 && nwait < 32) begin
            nwait++;
            cyc(SEL, 1'b1, w, a, d);
        end
        if (nwait >= 32) check("pready_timeout", {31'd0, Pready}, 32'd1);
        rdat = Prdata;
        serr = Pslverr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Hreset = 1'b1;
        idle(3);
        check("rst_prdata", Prdata, 32'h0);
        check("rst_slverr", {31'd0, Pslverr}, 32'd0);
        check("rst_prot", {31'd0, prot_err}, 32'd0);
        check("rst_count", {16'd0, xfer_count}, 32'd0);
        check("rst_pready", {31'd0, Pready}, {31'd0, EXP_IDLE_RDY});
        Hreset = 1'b0;
        idle(1);

        // Write then read; upper address bits are ignored
        xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, rd, err, waits);
        check("wr_slverr", {31'd0, err}, 32'd0);
        idle(1);
        xfer(1'b0, 32'h8000_0010, 32'h0, rd, err, waits);
        check("rd_data", rd, 32'hDEAD_BEEF);
        check("rd_slverr", {31'd0, err}, 32'd0);
        check("rd_waits", waits, EXP_WAIT);
        idle(1);
        check("cnt_after_wr_rd", {16'd0, xfer_count}, 32'd2);
        check("prdata_cleared", Prdata, 32'h0);
        check("idle_pready", {31'd0, Pready}, {31'd0, EXP_IDLE_RDY});

        // Register 0 is the read-only ID
        xfer(1'b1, 32'h0000_0000, 32'h1234_5678, rd, err, waits);
        check("id_wr_slverr", {31'd0, err}, 32'd0);
        idle(1);
        xfer(1'b0, 32'h0000_0000, 32'h0, rd, err, waits);
        check("id_rd_data", rd, 32'hA2B0_0593);
        check("id_rd_slverr", {31'd0, err}, 32'd0);
        idle(1);

        // Decode errors: misaligned read, out-of-range write, misaligned write
        xfer(1'b0, 32'h0000_0042, 32'h0, rd, err, waits);
        check("misal_rd_slverr", {31'd0, err}, 32'd1);
        check("misal_rd_data", rd, 32'h0);
        idle(1);
        xfer(1'b1, 32'h0000_0040, 32'hCAFE_F00D, rd, err, waits);
        check("oor_wr_slverr", {31'd0, err}, 32'd1);
        idle(1);
        xfer(1'b1, 32'h0000_0011, 32'h55AA_55AA, rd, err, waits);
        check("misal_wr_slverr", {31'd0, err}, 32'd1);
        idle(1);
        xfer(1'b0, 32'h0000_0010, 32'h0, rd, err, waits);
        check("reg4_intact", rd, 32'hDEAD_BEEF);
        idle(1);
        xfer(1'b0, 32'h0000_0000, 32'h0, rd, err, waits);
        check("id_intact", rd, 32'hA2B0_0593);
        idle(1);
        xfer(1'b1, 32'h0000_003C, 32'h0F0F_0F0F, rd, err, waits);
        check("last_wr_slverr", {31'd0, err}, 32'd0);
        idle(1);
        xfer(1'b0, 32'h0000_003C, 32'h0, rd, err, waits);
        check("last_rd_data", rd, 32'h0F0F_0F0F);
        idle(1);
        check("cnt_incl_errors", {16'd0, xfer_count}, 32'd11);

        // Back-to-back writes, then back-to-back reads and a write/read pair
        xfer(1'b1, 32'h0000_0004, 32'h1111_1111, rd, err, waits);
        xfer(1'b1, 32'h0000_0008, 32'h2222_2222, rd, err, waits);
        xfer(1'b1, 32'h0000_000C, 32'h3333_3333, rd, err, waits);
        idle(1);
        check("b2b_wr_count", {16'd0, xfer_count}, 32'd14);
        xfer(1'b0, 32'h0000_0004, 32'h0, rd, err, waits);
        check("b2b_rd4", rd, 32'h1111_1111);
        xfer(1'b0, 32'h0000_0008, 32'h0, rd, err, waits);
        check("b2b_rd8", rd, 32'h2222_2222);
        xfer(1'b0, 32'h0000_000C, 32'h0, rd, err, waits);
        check("b2b_rdC", rd, 32'h3333_3333);
        xfer(1'b1, 32'h0000_0030, 32'h0BAD_F00D, rd, err, waits);
        xfer(1'b0, 32'h0000_0030, 32'h0, rd, err, waits);
        check("wr_then_rd_same", rd, 32'h0BAD_F00D);
        idle(1);
        check("b2b_total_count", {16'd0, xfer_count}, 32'd19);
        check("b2b_no_prot", {31'd0, prot_err}, 32'd0);

        // Reset during the ACCESS phase of a write
        cyc(SEL, 1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_0020);
        cyc(SEL, 1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_0020);
        Hreset = 1'b1;
        cyc(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        Hreset = 1'b0;
        check("midrst_count", {16'd0, xfer_count}, 32'd0);
        check("midrst_prot", {31'd0, prot_err}, 32'd0);
        check("midrst_pready", {31'd0, Pready}, {31'd0, EXP_IDLE_RDY});
        xfer(1'b0, 32'h0000_0020, 32'h0, rd, err, waits);
        check("midrst_no_commit", rd, 32'h0);
        idle(1);
        xfer(1'b0, 32'h0000_0004, 32'h0, rd, err, waits);
        check("rst_clears_regs", rd, 32'h0);
        idle(1);
        check("midrst_reads_count", {16'd0, xfer_count}, 32'd2);

        // Penable asserted with select straight from IDLE
        cyc(SEL, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(1);
        check("prot_en_from_idle", {31'd0, prot_err}, 32'd1);
        check("prot_no_count", {16'd0, xfer_count}, 32'd2);
        idle(1);
        check("prot_sticky", {31'd0, prot_err}, 32'd1);
        Hreset = 1'b1;
        idle(1);
        Hreset = 1'b0;
        check("prot_cleared_by_rst", {31'd0, prot_err}, 32'd0);

        // Address changes between SETUP and ACCESS
        cyc(SEL, 1'b0, 1'b1, 32'h0000_0014, 32'hA5A5_A5A5);
        cyc(SEL, 1'b1, 1'b1, 32'h0000_0018, 32'hA5A5_A5A5);
        idle(1);
        check("prot_addr_change", {31'd0, prot_err}, 32'd1);
        check("prot_addr_no_count", {16'd0, xfer_count}, 32'd0);
        xfer(1'b0, 32'h0000_0014, 32'h0, rd, err, waits);
        check("prot_no_wr_14", rd, 32'h0);
        idle(1);
        xfer(1'b0, 32'h0000_0018, 32'h0, rd, err, waits);
        check("prot_no_wr_18", rd, 32'h0);
        idle(1);
        check("prot_reads_count", {16'd0, xfer_count}, 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
